// File: rtl/pe_typed_sched_pkg.sv
// Shared types for the PE_typeD request scheduler: operand width, op codes,
// scheduler states and the round-robin index helper.
package pe_typed_sched_pkg;

    localparam int dwidth_double = 64;

    typedef enum logic [1:0] {
        OP_PASS_A = 2'b00,
        OP_PASS_B = 2'b01,
        OP_DIV    = 2'b10,
        OP_SQRT   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_e;

    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/register_pipe.sv
// Fixed-depth delay line. The MSB is treated as a valid bit and is the only
// bit cleared by reset; the remaining payload bits are plain data flops.
module register_pipe #(
    parameter int width        = 8,
    parameter int numPipeStage = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic             vld [numPipeStage];
    logic [width-2:0] dat [numPipeStage];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < numPipeStage; i++) vld[i] <= 1'b0;
        end else begin
            vld[0] <= d[width-1];
            for (int i = 1; i < numPipeStage; i++) vld[i] <= vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dat[0] <= d[width-2:0];
        for (int i = 1; i < numPipeStage; i++) dat[i] <= dat[i-1];
    end

    assign q = {vld[numPipeStage-1], dat[numPipeStage-1]};

endmodule

// File: rtl/sched_result_fifo.sv
// Result buffer between the PE tag pipeline and the consumer. A write is
// accepted on a full FIFO when the head is popped in the same cycle.
module sched_result_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [width-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [width-1:0] rd_data
);

    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);
    localparam logic [AW-1:0] LAST = AW'(depth - 1);
    localparam logic [CW-1:0] FULL = CW'(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr, do_rd;

    assign rd_valid = (count != '0);
    assign do_rd    = rd_valid & rd_ready;
    assign do_wr    = wr_valid & ((count != FULL) | do_rd);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_typed_sched.sv
// Round-robin scheduler sharing one fixed-latency PE_typeD among NREQ
// requesters; results return in issue order through a credit-guarded FIFO.
//
//   state | meaning
//   IDLE  | nothing issued, waiting for en
//   RUN   | granting requests while credit is available
//   DRAIN | no grants; in-flight ops and buffered results finish
module pe_typed_sched
    import pe_typed_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int LATENCY    = 57,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ-1:0][1:0]                req_op,
    input  logic [NREQ-1:0][dwidth_double-1:0]  req_a,
    input  logic [NREQ-1:0][dwidth_double-1:0]  req_b,
    output logic [dwidth_double-1:0]            pe_inp1,
    output logic [dwidth_double-1:0]            pe_inp2,
    output logic [1:0]                          pe_op,
    output logic                                pe_vld,
    input  logic [dwidth_double-1:0]            pe_out,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [dwidth_double-1:0]            res_data,
    output logic [$clog2(NREQ)-1:0]             res_id,
    output logic                                idle
);

    localparam int IDW = $clog2(NREQ);
    localparam int TW  = 1 + IDW + 2;
    localparam int CRW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CRW-1:0] CREDIT_MAX = CRW'(FIFO_DEPTH);
    localparam logic [IDW-1:0] LAST_REQ   = IDW'(NREQ - 1);

    state_e                         state, state_nxt;
    logic [IDW-1:0]                 rr_ptr, gnt_idx, cand;
    logic                           gnt_found, issue_ok, issue, pop;
    logic [CRW-1:0]                 credit;
    logic [TW-1:0]                  tag_in, tag_out;
    logic                           tag_vld;
    logic [IDW-1:0]                 tag_id;
    logic [1:0]                     tag_op;
    logic                           unused_tag_op;
    logic [IDW+dwidth_double-1:0]   fifo_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = DRAIN;
            DRAIN:   if (en) state_nxt = RUN;
                     else if (credit == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idle     = (state == IDLE);
        issue_ok = (state == RUN) && (credit < CREDIT_MAX);
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'(rr_index(int'(rr_ptr), k, NREQ));
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign issue = issue_ok & gnt_found;
    assign pop   = res_valid & res_ready;

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[gnt_idx] = 1'b1;
    end

    assign pe_inp1 = req_a[gnt_idx];
    assign pe_inp2 = req_b[gnt_idx];
    assign pe_vld  = issue;
    assign pe_op   = issue ? req_op[gnt_idx] : OP_PASS_A;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            credit <= '0;
        end else begin
            if (issue) rr_ptr <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + IDW'(1);
            case ({issue, pop})
                2'b10:   credit <= credit + CRW'(1);
                2'b01:   credit <= credit - CRW'(1);
                default: credit <= credit;
            endcase
        end
    end

    // The tag shadows the PE pipeline; the PE's own valid output is ignored.
    assign tag_in = {issue, gnt_idx, pe_op};

    register_pipe #(
        .width        (TW),
        .numPipeStage (LATENCY)
    ) u_tag_pipe (
        .clk (clk),
        .rst (rst),
        .d   (tag_in),
        .q   (tag_out)
    );

    assign {tag_vld, tag_id, tag_op} = tag_out;
    assign unused_tag_op = ^tag_op;

    sched_result_fifo #(
        .width (IDW + dwidth_double),
        .depth (FIFO_DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (tag_vld),
        .wr_data  ({tag_id, pe_out}),
        .rd_valid (res_valid),
        .rd_ready (res_ready),
        .rd_data  (fifo_rd_data)
    );

    assign {res_id, res_data} = fifo_rd_data;

endmodule

// File: tb/tb_pe_typed_sched.sv
// Directed bench for pe_typed_sched with a behavioural PE_typeD model and an
// issue-order scoreboard of expected results.
module tb_pe_typed_sched;
    import pe_typed_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 57;
    localparam int FD   = 64;
    localparam int DW   = dwidth_double;

    typedef struct {
        int          id;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       en  = 1'b0;
    logic [NREQ-1:0]            req_valid = '0;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][1:0]       req_op = '0;
    logic [NREQ-1:0][DW-1:0]    req_a  = '0;
    logic [NREQ-1:0][DW-1:0]    req_b  = '0;
    logic [DW-1:0]              pe_inp1, pe_inp2, pe_out, res_data;
    logic [1:0]                 pe_op;
    logic                       pe_vld, res_valid, idle;
    logic                       res_ready = 1'b1;
    logic [1:0]                 res_id;

    int   n_cmp = 0, n_fail = 0, cyc = 0;
    int   model_p = 0, gnt_cnt = 0, gnt_last_cyc = 0, res_cnt = 0, res_last_cyc = 0;
    int   res_last_id = 0, mon_exp, mon_gi;
    logic [63:0] res_last_data = '0;
    bit   lat_exact = 1'b1;
    exp_t sb[$];
    exp_t e;
    logic [63:0] pe_pipe [LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_typed_sched #(.NREQ(NREQ), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .pe_inp1(pe_inp1), .pe_inp2(pe_inp2), .pe_op(pe_op), .pe_vld(pe_vld),
        .pe_out(pe_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .idle(idle)
    );

    function automatic logic [63:0] pe_func(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        case (op)
            2'b00:   return a;
            2'b01:   return b;
            2'b10:   return $realtobits($bitstoreal(a) / $bitstoreal(b));
            default: return $realtobits($sqrt($bitstoreal(a)));
        endcase
    endfunction

    // Behavioural PE_typeD: fixed LAT-cycle pipeline, valid output unused.
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pe_pipe[i] <= pe_pipe[i-1];
        pe_pipe[0] <= pe_vld ? pe_func(pe_op, pe_inp1, pe_inp2) : 64'h0;
    end
    assign pe_out = pe_pipe[LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            model_p = 0;
        end else begin
            if (|req_valid) check("grant_onehot0", 64'($onehot0(req_ready)), 64'd1);
            if (|(req_valid & req_ready)) begin
                mon_exp = -1;
                for (int k = 0; k < NREQ; k++)
                    if (mon_exp < 0 && req_valid[(model_p + k) % NREQ]) mon_exp = (model_p + k) % NREQ;
                mon_gi = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) mon_gi = i;
                check("rr_grant", 64'(mon_gi), 64'(mon_exp));
                check("pe_vld_issue", 64'(pe_vld), 64'd1);
                check("pe_op_mux", 64'(pe_op), 64'(req_op[mon_gi]));
                check("pe_inp1_mux", pe_inp1, req_a[mon_gi]);
                check("pe_inp2_mux", pe_inp2, req_b[mon_gi]);
                sb.push_back('{id: mon_gi, data: pe_func(req_op[mon_gi], req_a[mon_gi], req_b[mon_gi]),
                               cyc: cyc});
                model_p = (mon_gi + 1) % NREQ;
                gnt_cnt++;
                gnt_last_cyc = cyc;
            end else begin
                check("pe_vld_noissue", 64'(pe_vld), 64'd0);
            end
            if (res_valid && res_ready) begin
                check("res_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("res_id", 64'(res_id), 64'(e.id));
                    check("res_data", res_data, e.data);
                    if (lat_exact) check("res_latency", 64'(cyc - e.cyc), 64'(LAT + 1));
                end
                res_cnt++;
                res_last_cyc  = cyc;
                res_last_data = res_data;
                res_last_id   = int'(res_id);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gnt(input string tag, input int target, input int bound);
        int t = 0;
        while (gnt_cnt < target && t < bound) begin
            tick();
            t++;
        end
        check(tag, 64'(gnt_cnt), 64'(target));
    endtask

    task automatic wait_res(input string tag, input int target, input int bound);
        int t = 0;
        while (res_cnt < target && t < bound) begin
            tick();
            t++;
        end
        check(tag, 64'(res_cnt), 64'(target));
    endtask

    task automatic set_mixed_ops();
        req_op[0] = 2'b00; req_a[0] = $realtobits(7.0);  req_b[0] = $realtobits(1.0);
        req_op[1] = 2'b01; req_a[1] = $realtobits(1.0);  req_b[1] = $realtobits(2.5);
        req_op[2] = 2'b10; req_a[2] = $realtobits(9.0);  req_b[2] = $realtobits(4.0);
        req_op[3] = 2'b11; req_a[3] = $realtobits(2.25); req_b[3] = $realtobits(1.0);
    endtask

    initial begin
        int g0, r0, c0, c_iss, t;
        bit any_rdy;

        // Reset state, with requests and en already asserted
        set_mixed_ops();
        en = 1'b1;
        req_valid = '1;
        #1 rst = 1'b0;
        #11;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_pe_vld", 64'(pe_vld), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        req_valid = '0;
        req_op[0] = 2'b10;
        req_a[0]  = $realtobits(6.0);
        req_b[0]  = $realtobits(2.0);
        tick();
        rst = 1'b1;

        // Single divide from requester 0
        req_valid = 4'b0001;
        wait_gnt("s2_grant", 1, 20);
        c_iss = gnt_last_cyc;
        req_valid = '0;
        wait_res("s2_result", 1, 100);
        check("s2_latency", 64'(res_last_cyc - c_iss), 64'(LAT + 1));
        check("s2_data", res_last_data, $realtobits(3.0));
        check("s2_id", 64'(res_last_id), 64'd0);

        // All four requesters continuously, 16 ops
        set_mixed_ops();
        g0 = gnt_cnt;
        r0 = res_cnt;
        req_valid = '1;
        wait_gnt("s3_first_grant", g0 + 1, 20);
        c0 = gnt_last_cyc;
        wait_gnt("s3_grants", g0 + 16, 40);
        req_valid = '0;
        check("s3_grant_span", 64'(gnt_last_cyc - c0), 64'd15);
        wait_res("s3_first_result", r0 + 1, 100);
        c0 = res_last_cyc;
        wait_res("s3_results", r0 + 16, 40);
        check("s3_result_span", 64'(res_last_cyc - c0), 64'd15);

        // Consumer stalled: credit limits grants to the FIFO depth
        lat_exact = 1'b0;
        g0 = gnt_cnt;
        r0 = res_cnt;
        res_ready = 1'b0;
        req_valid = '1;
        wait_gnt("s4_grants", g0 + FD, 200);
        tick(20);
        check("s4_grant_total", 64'(gnt_cnt), 64'(g0 + FD));
        check("s4_ready_blocked", 64'(req_ready), 64'd0);
        req_valid = '0;
        res_ready = 1'b1;
        wait_res("s4_results", r0 + FD, 200);
        check("s4_sb_empty", 64'(sb.size()), 64'd0);
        lat_exact = 1'b1;

        // 32 ops, then en dropped; no grants in DRAIN, idle after last pop
        g0 = gnt_cnt;
        r0 = res_cnt;
        req_valid = '1;
        wait_gnt("s5_grants", g0 + 32, 100);
        req_valid = '0;
        en = 1'b0;
        tick(2);
        req_valid = '1;
        any_rdy = 1'b0;
        t = 0;
        while (res_cnt < r0 + 32 && t < 200) begin
            if (|req_ready) any_rdy = 1'b1;
            tick();
            t++;
        end
        check("s5_results", 64'(res_cnt), 64'(r0 + 32));
        check("s5_no_grant_drain", 64'(any_rdy), 64'd0);
        check("s5_grant_total", 64'(gnt_cnt), 64'(g0 + 32));
        check("s5_idle_before", 64'(idle), 64'd0);
        tick();
        check("s5_idle_rise", 64'(idle), 64'd1);
        check("s5_ready_idle", 64'(req_ready), 64'd0);
        req_valid = '0;

        // Reset with ops in flight discards them
        en = 1'b1;
        g0 = gnt_cnt;
        req_valid = '1;
        wait_gnt("s6_grants", g0 + 10, 50);
        req_valid = '0;
        tick(20);
        rst = 1'b0;
        req_valid = '1;
        tick(2);
        check("s6_rst_req_ready", 64'(req_ready), 64'd0);
        check("s6_rst_pe_vld", 64'(pe_vld), 64'd0);
        check("s6_rst_res_valid", 64'(res_valid), 64'd0);
        check("s6_rst_idle", 64'(idle), 64'd1);
        req_valid = '0;
        rst = 1'b1;
        r0 = res_cnt;
        tick(100);
        check("s6_no_stale", 64'(res_cnt), 64'(r0));
        req_op[2] = 2'b11;
        req_a[2]  = $realtobits(16.0);
        g0 = gnt_cnt;
        req_valid = 4'b0100;
        wait_gnt("s6_sqrt_grant", g0 + 1, 20);
        req_valid = '0;
        wait_res("s6_sqrt_result", r0 + 1, 100);
        check("s6_sqrt_data", res_last_data, $realtobits(4.0));
        check("s6_sqrt_id", 64'(res_last_id), 64'd2);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_typed_sched.md
PE_TYPED_SCHED -- requirements
Module: pe_typed_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one PE_typeD instance.
REQ-002 Parameter LATENCY, default 57: PE_typeD pipeline depth in cycles, identical for every op.
REQ-003 Parameter FIFO_DEPTH, default 64: result FIFO entries; FIFO_DEPTH SHALL be >= LATENCY+1.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  1 = issue permitted; 0 = stop issuing and drain.
REQ-007 req_valid  in  NREQ  per-requester operation request.
REQ-008 req_ready  out  NREQ  per-requester grant; transfer = req_valid[i] & req_ready[i].
REQ-009 req_op  in  NREQ x 2  op code: 00 pass a, 01 pass b, 10 a/b, 11 sqrt(a).
REQ-010 req_a, req_b  in  NREQ x dwidth_double each  operands.
REQ-011 pe_inp1, pe_inp2  out  dwidth_double each  operands to PE.
REQ-012 pe_op  out  2  op to PE; pe_vld  out  1  drives both PE t_valid inputs.
REQ-013 pe_out  in  dwidth_double  PE result; PE t_valid_out1 is not connected.
REQ-014 res_valid  out  1; res_ready  in  1; res_data  out  dwidth_double; res_id  out  clog2(NREQ)  requester index of result.
REQ-015 idle  out  1  high when state IDLE.

Function
REQ-016 At most one requester SHALL be granted per cycle; req_ready SHALL be one-hot or zero.
REQ-017 Arbitration SHALL be round-robin: search starts at pointer p; after a transfer from i, p becomes (i+1) mod NREQ; no transfer leaves p unchanged.
REQ-018 Grant SHALL be issued only in state RUN and only when credit < FIFO_DEPTH.
REQ-019 credit = in-flight ops + FIFO occupancy; +1 on issue, -1 on res_valid&res_ready; simultaneous issue and pop leave it unchanged.
REQ-020 On transfer, pe_inp1/pe_inp2/pe_op SHALL carry the granted payload in the same cycle (combinational mux) and pe_vld SHALL be 1; otherwise pe_vld=0, pe_op=00.
REQ-021 A tag pipeline of LATENCY stages SHALL carry {valid, requester index, op} in lockstep with the PE; the PE's own valid SHALL NOT be used.
REQ-022 When a tag with valid exits the pipeline, pe_out and the index SHALL be written into the FIFO that same cycle; credit guarantees the FIFO is never full at write.
REQ-023 FIFO head drives res_valid/res_data/res_id; results leave in issue order; simultaneous write and read on a full or empty FIFO SHALL be lossless (empty write-through not required; 1-cycle min latency from write to res_valid).
REQ-024 Issue-to-res_valid latency SHALL be LATENCY+1 cycles with res_ready held high.
REQ-025 FSM states IDLE, RUN, DRAIN: IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->IDLE when credit=0; DRAIN->RUN when en=1.
REQ-026 In DRAIN, req_ready SHALL be 0 while in-flight ops complete and FIFO continues to drain.
REQ-027 Throughput SHALL be one op per cycle sustained when res_ready=1 and requests pending.

Reset
REQ-028 While rst=0: state IDLE, p=0, credit=0, tag pipeline valid bits 0, FIFO empty; req_ready=0, pe_vld=0, res_valid=0, idle=1.
REQ-029 Reset mid-operation SHALL discard all in-flight and buffered results; no res_valid after release until new issue.
REQ-030 Data registers (operands, FIFO storage) need no reset.

Structure
REQ-031 Op-code enum (OP_PASS_A, OP_PASS_B, OP_DIV, OP_SQRT), FSM state enum and dwidth_double SHALL live in the shared package/include.
REQ-032 The result FIFO SHALL be a sub-module sched_result_fifo (parameters width, depth; valid/ready output side).
REQ-033 The tag pipeline SHALL reuse register_pipe with width 1+clog2(NREQ)+2, numPipeStage=LATENCY, reset on the valid bit.

Verification
REQ-034 en=1, req 0 only, op=10, a=6.0, b=2.0 -> res_valid after 58 cycles, res_data=3.0, res_id=0.
REQ-035 All 4 requesters valid continuously, 16 ops -> grants 0,1,2,3,0,... strictly, results in same order, one per cycle.
REQ-036 res_ready=0 held, requests pending -> exactly 64 grants, then req_ready=0; release res_ready -> 64 results, no loss.
REQ-037 32 ops issued, en dropped -> no further grants, idle rises exactly cycle after last result popped.
REQ-038 rst asserted 20 cycles after 10 issues -> no res_valid after release; new op=11, a=16.0 returns 4.0.
